conv_pool_writer: RTL and testbench

Streaming post-processing stage placed directly after `conv_blk`. It consumes the raster-ordered convolution results qualified by `o_en`, applies an optional 2x2/stride-2 signed max-pool, and generates the write port for the output feature-map BRAM. The write port carries address, data and write-enable. It also reports frame completion to the layer controller.

---
 rtl/conv_pool_writer.sv | 147 ++++++++++++++
 tb/tb_conv_pool_writer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_writer.sv
// Post-conv stage: optional 2x2/stride-2 signed max-pool feeding the output feature-map BRAM write port.
// Build option: define CONV_POOL_RELU_EN to clamp negative input samples to zero before pooling/output.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_go; input samples are discarded
// RUN   | accepting raster samples while i_en is high
// DONE  | one-cycle frame-complete indication, then back to IDLE
module conv_pool_writer #(
    parameter int DATA_W   = 48,
    parameter int OUT_SIZE = 4,
    parameter int POOL     = 2,
    localparam int WR_SIZE = OUT_SIZE / POOL,
    localparam int ADDR_W  = (WR_SIZE * WR_SIZE > 1) ? $clog2(WR_SIZE * WR_SIZE) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_go,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]         col, row;
    logic [ADDR_W-1:0]        wr_cnt;
    logic                     accept, start, last;
    logic signed [DATA_W-1:0] sample;
    logic                     wr_en_n;
    logic signed [DATA_W-1:0] wr_data_n;

    assign start  = (state == IDLE) && i_go;
    assign accept = (state == RUN) && i_en;
    assign last   = (row == LAST_IDX) && (col == LAST_IDX);

`ifdef CONV_POOL_RELU_EN
    assign sample = i_data[DATA_W-1] ? '0 : i_data;
`else
    assign sample = i_data;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (i_go) state_n = RUN;
            RUN:     if (accept && last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Raster position of the next sample; stalls whenever i_en is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col <= '0;
            row <= '0;
        end else if (start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    if (POOL == 1) begin : g_pass
        assign wr_en_n   = accept;
        assign wr_data_n = sample;
    end else begin : g_pool
        localparam int LB_DEPTH = (OUT_SIZE / 2 > 1) ? OUT_SIZE / 2 : 1;
        localparam int LB_W     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

        logic signed [DATA_W-1:0] pair, pair_max, lb_rd;
        logic signed [DATA_W-1:0] linebuf [LB_DEPTH];
        logic [LB_W-1:0]          lb_idx;

        assign lb_idx    = LB_W'(col >> 1);
        assign lb_rd     = linebuf[lb_idx];
        assign pair_max  = (pair > sample) ? pair : sample;
        assign wr_en_n   = accept && col[0] && row[0];
        assign wr_data_n = (lb_rd > pair_max) ? lb_rd : pair_max;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                pair <= '0;
            end else if (accept && !col[0]) begin
                pair <= sample;
            end
        end

        // Top-row pair maxima wait here for the matching bottom row; only odd columns
        // write, so the unpaired last column of an odd-sized map never indexes past the end.
        always_ff @(posedge i_clk) begin
            if (accept && col[0] && !row[0]) begin
                linebuf[lb_idx] <= pair_max;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            wr_cnt    <= '0;
        end else begin
            o_wr_en <= wr_en_n;
            if (start) begin
                wr_cnt <= '0;
            end else if (wr_en_n) begin
                o_wr_addr <= wr_cnt;
                o_wr_data <= wr_data_n;
                wr_cnt    <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);

endmodule

// File: tb/tb_conv_pool_writer.sv
// Directed bench for conv_pool_writer: three instances (4x4 pool, 3x3 pass-through, 5x5 pool) share one stimulus bus.
// Expected values follow CONV_POOL_RELU_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_conv_pool_writer;

    localparam int DW = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go, en;
    logic [DW-1:0] data;
    int            sel;
    int            cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic          go_a, en_a, go_b, en_b, go_c, en_c;
    logic          wr_en_a, busy_a, done_a, wr_en_b, busy_b, done_b, wr_en_c, busy_c, done_c;
    logic [1:0]    addr_a, addr_c;
    logic [3:0]    addr_b;
    logic [DW-1:0] wd_a, wd_b, wd_c;

    assign go_a = go && (sel == 0);
    assign en_a = en && (sel == 0);
    assign go_b = go && (sel == 1);
    assign en_b = en && (sel == 1);
    assign go_c = go && (sel == 2);
    assign en_c = en && (sel == 2);

    conv_pool_writer #(.DATA_W(DW), .OUT_SIZE(4), .POOL(2)) u_a (
        .i_clk(clk), .i_rst(rst), .i_go(go_a), .i_en(en_a), .i_data(data),
        .o_wr_en(wr_en_a), .o_wr_addr(addr_a), .o_wr_data(wd_a), .o_busy(busy_a), .o_done(done_a));

    conv_pool_writer #(.DATA_W(DW), .OUT_SIZE(3), .POOL(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_go(go_b), .i_en(en_b), .i_data(data),
        .o_wr_en(wr_en_b), .o_wr_addr(addr_b), .o_wr_data(wd_b), .o_busy(busy_b), .o_done(done_b));

    conv_pool_writer #(.DATA_W(DW), .OUT_SIZE(5), .POOL(2)) u_c (
        .i_clk(clk), .i_rst(rst), .i_go(go_c), .i_en(en_c), .i_data(data),
        .o_wr_en(wr_en_c), .o_wr_addr(addr_c), .o_wr_data(wd_c), .o_busy(busy_c), .o_done(done_c));

    logic          m_wr_en, m_busy, m_done;
    logic [7:0]    m_addr;
    logic [DW-1:0] m_data;

    always_comb begin
        m_wr_en = wr_en_a;
        m_busy  = busy_a;
        m_done  = done_a;
        m_addr  = 8'(addr_a);
        m_data  = wd_a;
        case (sel)
            1: begin
                m_wr_en = wr_en_b; m_busy = busy_b; m_done = done_b;
                m_addr  = 8'(addr_b); m_data = wd_b;
            end
            2: begin
                m_wr_en = wr_en_c; m_busy = busy_c; m_done = done_c;
                m_addr  = 8'(addr_c); m_data = wd_c;
            end
            default: ;
        endcase
    end

    longint wq_d[$];
    int     wq_a[$];
    int     wq_c[$];
    int     dq_c[$];

    always @(negedge clk) begin
        if (m_wr_en === 1'b1) begin
            wq_d.push_back(longint'($signed(m_data)));
            wq_a.push_back(int'(m_addr));
            wq_c.push_back(cyc);
        end
        if (m_done === 1'b1) dq_c.push_back(cyc);
    end

    int     n_chk = 0;
    int     n_err = 0;
    longint exp_d [25];
    int     acc   [25];

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint relu(input longint v);
`ifdef CONV_POOL_RELU_EN
        return (v < 0) ? 64'sd0 : v;
`else
        return v;
`endif
    endfunction

    // One clock of stimulus; returns the cycle in which the values were presented.
    task automatic drive(input logic g, input logic e, input longint v, output int at);
        go   = g;
        en   = e;
        data = DW'(v);
        at   = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_d.delete();
        wq_a.delete();
        wq_c.delete();
        dq_c.delete();
    endtask

    task automatic verify(input string tag, input int n);
        chk({tag, "_nwr"}, wq_d.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wq_d.size()) begin
                chk($sformatf("%s_a%0d", tag, i), wq_a[i], i);
                chk($sformatf("%s_d%0d", tag, i), wq_d[i], exp_d[i]);
            end
        end
    endtask

    // 4x4 frame on u_a. neg: stream -1..-16 instead of 0..15. noisy: IDLE samples,
    // go coinciding with i_en, and repeated go while running.
    task automatic run4(input string tag, input bit neg, input bit noisy);
        int t;
        sel = 0;
        clear_mon();
        if (noisy) begin
            for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 100, t);
            drive(1'b1, 1'b1, 99, t);
        end else begin
            drive(1'b1, 1'b0, 0, t);
        end
        chk({tag, "_busy_run"}, m_busy, 1);
        for (int i = 0; i < 16; i++) begin
            drive(noisy && (i == 5 || i == 6), 1'b1, neg ? -(i + 1) : i, acc[i]);
        end
        chk({tag, "_done"}, m_done, 1);
        drive(1'b0, 1'b0, 0, t);
        chk({tag, "_busy_end"}, m_busy, 0);
        chk({tag, "_done_end"}, m_done, 0);
        if (neg) begin
            exp_d[0] = relu(-1); exp_d[1] = relu(-3); exp_d[2] = relu(-9); exp_d[3] = relu(-11);
        end else begin
            exp_d[0] = 5; exp_d[1] = 7; exp_d[2] = 13; exp_d[3] = 15;
        end
        verify(tag, 4);
        chk({tag, "_ndone"}, dq_c.size(), 1);
        if (dq_c.size() > 0) chk({tag, "_done_cyc"}, dq_c[0], acc[15] + 1);
        if (wq_c.size() == 4) chk({tag, "_last_wr_cyc"}, wq_c[3], acc[15] + 1);
    endtask

    initial begin
        int t;
        go   = 1'b0;
        en   = 1'b0;
        data = '0;
        sel  = 0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", m_wr_en, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_data", m_data, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_done", m_done, 0);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 0, t);

        run4("pos", 1'b0, 1'b0);
        run4("neg", 1'b1, 1'b0);

        // 3x3 pass-through with a bubble after every sample
        sel = 1;
        clear_mon();
        drive(1'b1, 1'b0, 0, t);
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, i * 7 - 20, acc[i]);
            exp_d[i] = relu(i * 7 - 20);
            if (i < 8) drive(1'b0, 1'b0, 'hBEEF, t);
        end
        drive(1'b0, 1'b0, 0, t);
        chk("p1_busy_end", m_busy, 0);
        verify("p1", 9);
        for (int i = 0; i < 9; i++) begin
            if (i < wq_c.size()) chk($sformatf("p1_lat%0d", i), wq_c[i], acc[i] + 1);
        end
        chk("p1_ndone", dq_c.size(), 1);
        if (dq_c.size() > 0) chk("p1_done_cyc", dq_c[0], acc[8] + 1);

        // 5x5 pool: last row and column form no window
        sel = 2;
        clear_mon();
        drive(1'b1, 1'b0, 0, t);
        for (int i = 0; i < 25; i++) drive(1'b0, 1'b1, i, acc[i]);
        drive(1'b0, 1'b0, 0, t);
        exp_d[0] = 6; exp_d[1] = 8; exp_d[2] = 16; exp_d[3] = 18;
        verify("odd", 4);
        if (wq_c.size() == 4) chk("odd_last_wr_cyc", wq_c[3], acc[18] + 1);
        chk("odd_ndone", dq_c.size(), 1);
        if (dq_c.size() > 0) chk("odd_done_cyc", dq_c[0], acc[24] + 1);

        run4("noisy", 1'b0, 1'b1);

        // Asynchronous reset mid-frame, right as the first window is being written
        sel = 0;
        clear_mon();
        drive(1'b1, 1'b0, 0, t);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, i, t);
        chk("mid_wr_en", m_wr_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_en", m_wr_en, 0);
        chk("arst_addr", m_addr, 0);
        chk("arst_data", m_data, 0);
        chk("arst_busy", m_busy, 0);
        chk("arst_done", m_done, 0);
        en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 0, t);
        chk("arst_nwr", wq_d.size(), 0);
        chk("arst_ndone", dq_c.size(), 0);
        run4("again", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
